// File: rtl/uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | uart_pkg : shared UART constants and receiver state encoding    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_DATA_WIDTH   = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | uart_rx_if : receiver-to-FIFO write port (we/w_data/full)       |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface uart_rx_if #(
  parameter int DATA_WIDTH = uart_pkg::DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] r_data;
  logic                  valid;
  logic                  full;

  modport master (output r_data, output valid, input full);
  modport slave  (input r_data, input valid, output full);
endinterface : uart_rx_if
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer, async active-low reset        |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | uart_rx : 8N1 serial receiver feeding a FIFO write port         |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
  input  wire          clk,
  input  wire          rst,
  input  wire          rx,
  uart_rx_if.master    fifo,
  output logic         frame_err,
  output logic         overrun,
  output logic         busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  logic rxs;

  sync_2ff #(
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  uart_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      r_data_q    <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      r_data_q    <= r_data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    r_data_d    = r_data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DATA_WIDTH-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        // Leaving at mid-stop lets a start bit right after the stop bit be caught.
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
            if (fifo.full) begin
              overrun_d = 1'b1;
            end else begin
              r_data_d = shift_q;
              valid_d  = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fifo.r_data = r_data_q;
  assign fifo.valid  = valid_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != IDLE);

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------+
// | tb_uart_rx : scoreboard bench for uart_rx at 16 clocks per bit  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DW  = 8;
  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_OVR   = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  logic frame_err, overrun, busy;

  uart_rx_if #(.DATA_WIDTH(DW)) fifo_if ();

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .fifo      (fifo_if.master),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb_q[$];
  exp_t       mon_e;
  int         mon_kind;
  int         last_valid_cyc = -1;
  int         prev_valid_cyc = -1;
  logic [7:0] model_rdata = 8'h00;

  // Scoreboard: every output pulse consumes one expected event.
  always @(negedge clk) begin
    if (rst && (fifo_if.valid || frame_err || overrun)) begin
      checks++;
      mon_kind = fifo_if.valid ? K_VALID : (frame_err ? K_FERR : K_OVR);
      if (fifo_if.valid) begin
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
      end
      if ((int'(fifo_if.valid) + int'(frame_err) + int'(overrun)) != 1) begin
        errors++;
        $display("FAIL pulse_exclusive valid=%b frame_err=%b overrun=%b required exactly one",
                 fifo_if.valid, frame_err, overrun);
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse kind=%0d r_data=%02h required no pulse",
                 mon_kind, fifo_if.r_data);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_kind !== mon_e.kind || fifo_if.r_data !== mon_e.data) begin
          errors++;
          $display("FAIL pulse_match kind=%0d r_data=%02h required kind=%0d r_data=%02h",
                   mon_kind, fifo_if.r_data, mon_e.kind, mon_e.data);
        end
      end
    end
  end

  task automatic push_exp(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called and returns at 1ns after a rising edge so frames can be chained.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t_fall);
    logic [9:0] bits;
    bits   = {stop_bit, b, 1'b0};
    t_fall = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      wait_cycles(CPB);
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb_q.size() != 0; i++) wait_cycles(1);
  endtask

  task automatic test_reset();
    fifo_if.full = 1'b0;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fifo_if.valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0 ||
        busy !== 1'b0 || fifo_if.r_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_values valid=%b ferr=%b ovr=%b busy=%b r_data=%02h required all 0",
               fifo_if.valid, frame_err, overrun, busy, fifo_if.r_data);
    end
    rst = 1'b1;
    wait_cycles(4);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b required 0", busy);
    end
  endtask

  task automatic test_single_frame();
    int t_fall;
    push_exp(K_VALID, 8'hA5);
    model_rdata = 8'hA5;
    send_frame(8'hA5, 1'b1, t_fall);
    wait_drain(20);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL a5_missing pending=%0d required 0", sb_q.size());
      sb_q.delete();
    end
    checks++;
    if (last_valid_cyc - t_fall != 8 + 9 * CPB + 1 + 2) begin
      errors++;
      $display("FAIL a5_latency got=%0d required=%0d", last_valid_cyc - t_fall, 8 + 9 * CPB + 3);
    end
    checks++;
    if (fifo_if.r_data !== 8'hA5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL a5_hold r_data=%02h busy=%b required A5 0", fifo_if.r_data, busy);
    end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(10);
    checks++;
    if (busy !== 1'b0 || fifo_if.r_data !== model_rdata) begin
      errors++;
      $display("FAIL glitch busy=%b r_data=%02h required 0 %02h", busy, fifo_if.r_data, model_rdata);
    end
  endtask

  task automatic test_framing();
    int t_fall;
    push_exp(K_FERR, model_rdata);
    send_frame(8'h3C, 1'b0, t_fall);
    wait_cycles(40);
    checks++;
    if (busy !== 1'b1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL ferr_break busy=%b pending=%0d required 1 0", busy, sb_q.size());
      sb_q.delete();
    end
    rx = 1'b1;
    wait_cycles(5);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL break_exit busy=%b required 0", busy);
    end
    push_exp(K_VALID, 8'h11);
    model_rdata = 8'h11;
    send_frame(8'h11, 1'b1, t_fall);
    wait_drain(20);
    checks++;
    if (sb_q.size() != 0 || fifo_if.r_data !== 8'h11) begin
      errors++;
      $display("FAIL after_ferr pending=%0d r_data=%02h required 0 11", sb_q.size(), fifo_if.r_data);
      sb_q.delete();
    end
  endtask

  task automatic test_overrun();
    int t_fall;
    push_exp(K_VALID, 8'h42);
    model_rdata = 8'h42;
    send_frame(8'h42, 1'b1, t_fall);
    fifo_if.full = 1'b1;
    push_exp(K_OVR, 8'h42);
    send_frame(8'h99, 1'b1, t_fall);
    wait_drain(20);
    fifo_if.full = 1'b0;
    checks++;
    if (sb_q.size() != 0 || fifo_if.r_data !== 8'h42) begin
      errors++;
      $display("FAIL overrun pending=%0d r_data=%02h required 0 42", sb_q.size(), fifo_if.r_data);
      sb_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    push_exp(K_VALID, 8'h00);
    push_exp(K_VALID, 8'hFF);
    model_rdata = 8'hFF;
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    wait_drain(20);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_missing pending=%0d required 0", sb_q.size());
      sb_q.delete();
    end
    checks++;
    if (last_valid_cyc - prev_valid_cyc != 10 * CPB) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d required=%0d", last_valid_cyc - prev_valid_cyc, 10 * CPB);
    end
  endtask

  task automatic test_reset_mid_frame();
    int         t_fall;
    logic [9:0] bits;
    bits = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rx = bits[i];
      wait_cycles(CPB);
    end
    rx = bits[4];
    wait_cycles(CPB / 2);
    rst = 1'b0;
    #1;
    checks++;
    if (fifo_if.valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0 ||
        busy !== 1'b0 || fifo_if.r_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset valid=%b ferr=%b ovr=%b busy=%b r_data=%02h required all 0",
               fifo_if.valid, frame_err, overrun, busy, fifo_if.r_data);
    end
    rx = 1'b1;
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(5);
    checks++;
    if (busy !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_idle busy=%b pending=%0d required 0 0", busy, sb_q.size());
    end
    push_exp(K_VALID, 8'h5A);
    model_rdata = 8'h5A;
    send_frame(8'h5A, 1'b1, t_fall);
    wait_drain(20);
    checks++;
    if (sb_q.size() != 0 || fifo_if.r_data !== 8'h5A) begin
      errors++;
      $display("FAIL fresh_5a pending=%0d r_data=%02h required 0 5A", sb_q.size(), fifo_if.r_data);
      sb_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d required completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    wait_cycles(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that samples the asynchronous rx line, deserializes 8N1 frames (LSB first), and emits each byte as a one-cycle write strobe.
- Its outputs connect directly to the receive FIFO's we/w_data/full ports.
- It is the counterpart to the transmit path, where fifo_tx drains bytes to the serializer.
- Flags framing errors and overruns (FIFO full when a byte completes).

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200); must be >= 4.
- DATA_WIDTH, 8, data bits per frame; must match FIFO_DATA_WIDTH of the receive FIFO.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- full  input  1  receive FIFO full flag.
- r_data  output  DATA_WIDTH  last accepted byte; drives FIFO w_data.
- valid  output  1  one-cycle pulse when r_data is new; drives FIFO we.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good frame dropped because full=1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock (clk); reset asynchronous, active-low (rst low clears immediately).
  - Reset values: r_data=0, valid=0, frame_err=0, overrun=0, busy=0, state=IDLE.
  - Synchronizer flops reset to 1.
- rx input: passes through a 2-flop synchronizer; all decisions use the synchronized value rxs.
- Bit-timing counter: 0..CLKS_PER_BIT-1.
- Bit index: 0..DATA_WIDTH-1.
- Data register: shifts right; new bit enters at the MSB, giving LSB-first assembly.
- IDLE:
  - rxs==0 -> START, counter=0.
- START:
  - Counter reaches CLKS_PER_BIT/2-1 (integer division): sample rxs.
  - Sample 0 -> DATA, counter=0, index=0.
  - Sample 1 -> false start, return to IDLE. No pulse is raised.
- DATA:
  - Counter reaches CLKS_PER_BIT-1: sample rxs into the shift register, counter=0.
  - If index==DATA_WIDTH-1 -> STOP; otherwise index+1.
- STOP:
  - Counter reaches CLKS_PER_BIT-1: sample rxs.
  - Sample 1, full=0: r_data<=shift register and valid=1 on the next cycle. Go to IDLE.
  - Sample 1, full=1: overrun=1 on the next cycle. r_data unchanged, byte dropped. Go to IDLE.
  - Sample 0: frame_err=1 on the next cycle. No valid, r_data unchanged. Go to BREAK.
- BREAK:
  - Waits for rxs==1, then -> IDLE. A line held low never retriggers a frame.
- Pulse rules:
  - valid, frame_err and overrun are registered and mutually exclusive.
  - Each is high for exactly one cycle per frame.
- Latency: measured from the first cycle rxs==0.
  - Start sample at +CLKS_PER_BIT/2.
  - Data bit i sampled at +CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT.
  - Stop bit sampled at +CLKS_PER_BIT/2 + (DATA_WIDTH+1)*CLKS_PER_BIT.
  - valid one cycle after the stop sample.
  - Add 2 cycles of synchronizer delay from the rx pin.
- Back-to-back frames: returning to IDLE at mid-stop bit allows detection of a start bit that immediately follows the stop bit.
- full is sampled only at the stop-sample cycle. Its value at other times is ignored.
- Reset mid-frame: the frame is abandoned and no pulses are raised. After reset deassertion, the receiver waits in IDLE for the next falling rxs.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, STOP, BREAK);
  - default CLKS_PER_BIT and DATA_WIDTH constants, shared with the transmit path.
- One sub-module: sync_2ff, a 2-flop synchronizer with async active-low reset and a reset value parameter (1 here).

Test Plan (CLKS_PER_BIT=16, DATA_WIDTH=8):
1. Frame 0xA5 with stop=1, full=0.
   - valid high exactly 1 cycle, r_data=0xA5, frame_err=0, overrun=0.
   - valid asserts 8+9*16+1+2 cycles after the rx falling edge.
2. rx low for 4 cycles, then high (glitch).
   - No valid or frame_err; busy returns to 0 within 10 cycles.
3. Frame 0x3C with stop=0, then rx held low for 40 more cycles, then high.
   - One frame_err pulse, no valid; no new frame starts until rx rises.
   - A following frame 0x11 gives r_data=0x11.
4. After receiving 0x42, send frame 0x99 with full=1 held.
   - overrun pulses once, valid=0, r_data remains 0x42.
5. Back-to-back frames 0x00 then 0xFF, no idle gap.
   - Two valid pulses 160 cycles apart; r_data=0x00, then 0xFF.
6. rst low during data bit 3 of 0x5A.
   - All outputs 0 immediately, busy=0.
   - After rst high, a fresh frame 0x5A yields valid with r_data=0x5A.
